// File: rtl/mult_pkg.sv
// Shared constants and per-stage record for the segmented final carry-propagate adder.
// Latency: n/a (types only). Backpressure: n/a.
// Each stage record carries the partly resolved result plus the unresolved operands.
package mult_pkg;

  localparam int WIDTH   = 64;
  localparam int SEG_W   = 16;
  localparam int NUM_SEG = WIDTH / SEG_W;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cy;
    logic             ovf;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  // The tree's CARRY row is weighted by two; the bit shifted out seeds the overflow flag.
  function automatic stage_t seed_stage(input logic             vld,
                                        input logic [WIDTH-1:0] sum,
                                        input logic [WIDTH-1:0] carry);
    stage_t s;
    s     = '0;
    s.v   = vld;
    s.opa = sum;
    s.opb = {carry[WIDTH-2:0], 1'b0};
    s.cy  = 1'b0;
    s.ovf = carry[WIDTH-1];
    return s;
  endfunction

endpackage

// File: rtl/cpa_segment.sv
// One registered adder stage: holds a record, resolves segment IDX of it combinationally downstream.
// Latency: 1 cycle. Backpressure: accepts when empty or when downstream takes the held record.
module cpa_segment
  import mult_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STAGE_W-1:0] up_dat_i,
  output logic               up_rdy_o,
  output logic [STAGE_W-1:0] dn_dat_o,
  input  logic               dn_rdy_i
);

  localparam int LO   = IDX * SEG_W;
  localparam bit LAST = (IDX == NUM_SEG - 1);

  stage_t         up_s;
  stage_t         stage_d;
  stage_t         stage_q;
  stage_t         dn_s;
  logic [SEG_W:0] seg_sum;

  assign up_s     = up_dat_i;
  assign up_rdy_o = !stage_q.v || dn_rdy_i;

  // Data only loads on a real capture, so idle stages keep their last contents.
  always_comb begin
    stage_d = stage_q;
    if (up_rdy_o) begin
      if (up_s.v) begin
        stage_d = up_s;
      end else begin
        stage_d.v = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign seg_sum = {1'b0, stage_q.opa[LO +: SEG_W]}
                 + {1'b0, stage_q.opb[LO +: SEG_W]}
                 + {{SEG_W{1'b0}}, stage_q.cy};

  always_comb begin
    dn_s                  = stage_q;
    dn_s.res[LO +: SEG_W] = seg_sum[SEG_W-1:0];
    dn_s.cy               = seg_sum[SEG_W];
    if (LAST) begin
      dn_s.ovf = stage_q.ovf | seg_sum[SEG_W];
    end
  end

  assign dn_dat_o = dn_s;

endmodule

// File: rtl/final_cpa_pipe.sv
// Pipelined final carry-propagate adder: SUM + (CARRY<<1) resolved SEG_W bits per stage.
// Latency: NUM_SEG cycles, 1 result per cycle. Backpressure: bubbles collapse; in_ready drops only when full and stalled.
module final_cpa_pipe
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic             out_ovf
);

  logic [NUM_SEG:0][STAGE_W-1:0] link;
  logic [NUM_SEG:0]              rdy;
  stage_t                        tail_s;
  logic                          unused_tail;

  assign link[0]      = seed_stage(in_valid, in_sum, in_carry);
  assign rdy[NUM_SEG] = out_ready;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    cpa_segment #(
      .IDX (k)
    ) u_seg (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_dat_i (link[k]),
      .up_rdy_o (rdy[k]),
      .dn_dat_o (link[k+1]),
      .dn_rdy_i (rdy[k+1])
    );
  end

  // The last stage's output is fully resolved; its operand copies are no longer needed.
  assign tail_s      = link[NUM_SEG];
  assign unused_tail = ^{tail_s.opa, tail_s.opb, tail_s.cy};

  assign in_ready  = rdy[0];
  assign out_valid = tail_s.v;
  assign out_prod  = tail_s.res;
  assign out_ovf   = tail_s.ovf;

endmodule

// File: tb/tb_final_cpa_pipe.sv
// Scoreboard bench for final_cpa_pipe: directed corner cases plus randomized traffic with stalls.
module tb_final_cpa_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_sum = '0;
  logic [63:0] in_carry = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_prod;
  logic        out_ovf;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [64:0] exp_q[$];
  bit rnd_stall = 1'b0;

  always #5 clk = ~clk;

  final_cpa_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_ovf   (out_ovf)
  );

  // Reference: exact integer value of sum + 2*carry; anything at or above 2^64 is overflow.
  function automatic logic [64:0] model(input logic [63:0] s, input logic [63:0] c);
    logic [65:0] full;
    full = {2'b00, s} + ({2'b00, c} * 66'd2);
    return {(full[65:64] != 2'b00), full[63:0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got prod %0h with empty scoreboard at %0t", out_prod, $time);
        end else begin
          e = exp_q.pop_front();
          chk("prod", {64'h0, out_prod}, {64'h0, e[63:0]});
          chk("ovf", {127'h0, out_ovf}, {127'h0, e[64]});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sum, in_carry));
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [63:0] s, input logic [63:0] c);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("send_timeout", {127'h0, in_ready}, 128'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = '0;
      2: r = r & 64'h0000_FFFF_0000_FFFF;
      3: r = r | 64'hFFFF_0000_FFFF_0000;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
    chk("rst_out_prod", {64'h0, out_prod}, 128'h0);
    chk("rst_out_ovf", {127'h0, out_ovf}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed 1: latency and low-segment carry
    out_ready = 1'b1;
    send(64'h0000_0000_0000_FFFF, 64'h1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("t1_latency", lat, 4);
    wait_drain();

    // Directed 2 and 3: full ripple and dropped shift bit
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    send(64'h0, 64'h8000_0000_0000_0000);
    wait_drain();

    // Directed 4: fill under stall, then burst out
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) send(64'(v), 64'h0);
    in_valid = 1'b1;
    in_sum   = 64'd5;
    in_carry = 64'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_in_ready_full", {127'h0, in_ready}, 128'h0);
      chk("t4_held_valid", {127'h0, out_valid}, 128'h1);
      chk("t4_held_prod", {64'h0, out_prod}, 128'h1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_burst_valid", {127'h0, out_valid}, 128'h1);
      if (i == 0) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    wait_drain();

    // Directed 5: sparse input under a long stall, bubbles must collapse
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_sum   = 64'(100 + i);
      in_carry = 64'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_accepted", acc_cnt - acc0, 4);
    chk("t5_in_ready", {127'h0, in_ready}, 128'h0);
    chk("t5_out_valid", {127'h0, out_valid}, 128'h1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Directed 6: reset with three transactions in flight
    send(64'h11, 64'h1);
    send(64'h22, 64'h2);
    send(64'h33, 64'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("t6_rst_in_ready", {127'h0, in_ready}, 128'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_quiet", {127'h0, out_valid}, 128'h0);
    end

    // Random traffic with random downstream stalls
    rnd_stall = 1'b1;
    fork
      begin
        while (rnd_stall) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rnd64(), rnd64());
    end
    rnd_stall = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
